// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory arbiter.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  // Core request attributes carried to the response cycle.
  typedef struct packed {
    logic       vld;
    logic       err;
    logic       wr;
    logic [1:0] size;
    logic [1:0] off;
    logic       uns;
  } cresp_t;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      SZ_B:    return uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    return uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// DEPTH x 32 single-port RAM, byte write enables, registered read.
module dmem_sram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
  end

  // Read register only moves on reads so it holds between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             rdata <= '0;
    else if (en && !we)     rdata <= mem_q[addr];
  end

endmodule

// File: rtl/dmem_arb.sv
// Core/video arbiter over a shared word RAM with post-reset clear sequence.
module dmem_arb
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int VADDR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  input  logic               vreq,
  output logic               vreq_ready,
  input  logic [VADDR_W-1:0] vaddr,
  output logic               vvalid,
  output logic [31:0]        vdata,
  output logic               busy
);

  localparam int AW = $clog2(DEPTH);

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic          last_core_q;
  cresp_t        cr_q;
  logic          vvld_q;
  logic [31:0]   rhold_q, vhold_q;

  logic          run, core_gnt, vid_gnt;
  logic [1:0]    off;
  logic          oor, mis, err;
  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata, vext, rdata_now;
  logic          unused_bits;

  assign run      = (state_q == ST_RUN);
  assign core_gnt = run && req_valid && (!vreq || !last_core_q);
  assign vid_gnt  = run && vreq && !core_gnt;

  assign req_ready  = core_gnt;
  assign vreq_ready = vid_gnt;
  assign busy       = (state_q == ST_CLEAR);

  assign off = req_addr[1:0];
  assign oor = |(req_addr >> (AW + 2));
  assign mis = ((req_size == SZ_H) && off[0]) || ((req_size == SZ_W) && (off != 2'b00));
  assign err = oor || mis || (req_size == 2'b11);

  // Video word index is truncated or zero-extended to the RAM index width.
  assign vext        = 32'(vaddr[VADDR_W-1:2]);
  assign unused_bits = ^{vaddr[1:0], vext};

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!run) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_be   = 4'hF;
      ram_addr = ptr_q;
    end else if (core_gnt) begin
      ram_en    = 1'b1;
      ram_we    = req_write && !err;
      ram_be    = lane_be(req_size, off);
      ram_addr  = req_addr[AW+1:2];
      ram_wdata = req_wdata << {off, 3'b000};
    end else if (vid_gnt) begin
      ram_en   = 1'b1;
      ram_addr = vext[AW-1:0];
    end
  end

  dmem_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      last_core_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == AW'(DEPTH - 1)) state_q <= ST_RUN;
        end
        default: begin
          if (core_gnt)     last_core_q <= 1'b1;
          else if (vid_gnt) last_core_q <= 1'b0;
        end
      endcase
    end
  end

  // Stores and errored accesses answer with zero data.
  assign rdata_now = (cr_q.err || cr_q.wr) ? 32'h0
                   : load_ext(ram_rdata, cr_q.size, cr_q.off, cr_q.uns);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q    <= '0;
      vvld_q  <= 1'b0;
      rhold_q <= '0;
      vhold_q <= '0;
    end else begin
      cr_q.vld <= core_gnt;
      if (core_gnt) begin
        cr_q.err  <= err;
        cr_q.wr   <= req_write;
        cr_q.size <= req_size;
        cr_q.off  <= off;
        cr_q.uns  <= req_unsigned;
      end
      vvld_q <= vid_gnt;
      if (cr_q.vld) rhold_q <= rdata_now;
      if (vvld_q)   vhold_q <= ram_rdata;
    end
  end

  assign resp_valid = cr_q.vld;
  assign resp_err   = cr_q.vld && cr_q.err;
  assign resp_rdata = cr_q.vld ? rdata_now : rhold_q;
  assign vvalid     = vvld_q;
  assign vdata      = vvld_q ? ram_rdata : vhold_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: expected responses queued at accept, checked on arrival.
module tb_dmem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        vreq = 1'b0, vreq_ready, vvalid, busy;
  logic [8:0]  vaddr = '0;
  logic [31:0] vdata;

  dmem_arb #(.DEPTH(32), .VADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .vreq(vreq), .vreq_ready(vreq_ready), .vaddr(vaddr),
    .vvalid(vvalid), .vdata(vdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t cq[$];
  exp_t vq[$];
  int   errors = 0, checks = 0, cyc_n = 0, id_n = 0;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_c(input logic [31:0] d, input logic e);
    cq.push_back('{id_n, cyc_n + 1, d, e});
    id_n++;
  endtask

  task automatic push_v(input logic [31:0] d);
    vq.push_back('{id_n, cyc_n + 1, d, 1'b0});
    id_n++;
  endtask

  // Responses must appear exactly in the cycle after the accept edge.
  always @(negedge clk) begin
    exp_t e;
    if (cq.size() != 0 && cq[0].due == cyc_n) begin
      e = cq.pop_front();
      checks++;
      assert (resp_valid === 1'b1 && resp_rdata === e.d && resp_err === e.e) else begin
        errors++;
        $error("FAIL core_resp#%0d got v=%b d=%h err=%b exp v=1 d=%h err=%b",
               e.id, resp_valid, resp_rdata, resp_err, e.d, e.e);
      end
    end else if (resp_valid !== 1'b0) begin
      checks++;
      errors++;
      $error("FAIL core_spurious got v=%b exp v=0", resp_valid);
    end
    if (vq.size() != 0 && vq[0].due == cyc_n) begin
      e = vq.pop_front();
      checks++;
      assert (vvalid === 1'b1 && vdata === e.d) else begin
        errors++;
        $error("FAIL video_resp#%0d got v=%b d=%h exp v=1 d=%h", e.id, vvalid, vdata, e.d);
      end
    end else if (vvalid !== 1'b0) begin
      checks++;
      errors++;
      $error("FAIL video_spurious got v=%b exp v=0", vvalid);
    end
  end

  task automatic core_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    #1 chk("core_ready", 32'(req_ready), 32'd1);
    if (req_ready) push_c(er, ee);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0; vreq = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_clear(output int n);
    int bad;
    n = 0; bad = 0;
    while (n < 100) begin
      #1;
      if (!busy) break;
      if (req_ready || vreq_ready) bad++;
      n++;
      @(negedge clk);
    end
    chk("ready_in_clear", 32'(bad), 32'd0);
  endtask

  task automatic both(input int n, input logic first_core, input logic [31:0] ca,
                      input logic [31:0] cexp, input logic [8:0] va, input logic [31:0] vexp,
                      output int nc, output int nv);
    logic ec;
    nc = 0; nv = 0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = ca;
    vreq = 1'b1; vaddr = va;
    for (int i = 0; i < n; i++) begin
      ec = (i % 2 == 0) ? first_core : !first_core;
      #1;
      chk("arb_core", 32'(req_ready), 32'(ec));
      chk("arb_video", 32'(vreq_ready), 32'(!ec));
      if (req_ready) begin push_c(cexp, 1'b0); nc++; end
      if (vreq_ready) begin push_v(vexp); nv++; end
      @(negedge clk);
    end
    req_valid = 1'b0; vreq = 1'b0;
  endtask

  initial begin
    int n, nc, nv;
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_vvalid", 32'(vvalid), 32'd0);
    chk("rst_ready", {req_ready, vreq_ready}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_vdata", vdata, 32'd0);

    // Both ports request through the whole clear, then keep requesting.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h7C;
    vreq = 1'b1; vaddr = 9'h1FC;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wait_clear(n);
    chk("clear_cycles", 32'(n), 32'd32);
    both(6, 1'b1, 32'h7C, 32'h0, 9'h1FC, 32'h0, nc, nv);
    chk("arb0_core_cnt", 32'(nc), 32'd3);
    chk("arb0_video_cnt", 32'(nv), 32'd3);

    // Sign/zero extension; store immediately followed by load of the same word.
    core_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8000_00F1, 32'h0, 1'b0);
    core_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFF1, 1'b0);
    core_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h0000_00F1, 1'b0);
    core_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0);
    core_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_8000, 1'b0);
    idle();

    // Byte store into the middle of a word.
    core_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h1122_3344, 32'h0, 1'b0);
    core_req(1'b1, 2'b00, 1'b0, 32'h05, 32'h0000_00AB, 32'h0, 1'b0);
    core_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h1122_AB44, 1'b0);
    idle();

    // Error cases must not touch RAM.
    core_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1);
    core_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000_FFFF, 32'h0, 1'b1);
    core_req(1'b1, 2'b11, 1'b0, 32'h04, 32'hDEAD_BEEF, 32'h0, 1'b1);
    core_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFE_F00D, 32'h0, 1'b1);
    core_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
    core_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    core_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h1122_AB44, 1'b0);
    core_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8000_00F1, 1'b0);
    idle();

    // Last grant was core, so video wins first; vaddr 0x123 folds to word 8.
    core_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 1'b0);
    core_req(1'b1, 2'b10, 1'b0, 32'h24, 32'h9ABC_DEF0, 32'h0, 1'b0);
    both(6, 1'b0, 32'h24, 32'h9ABC_DEF0, 9'h123, 32'h1234_5678, nc, nv);
    chk("arb1_core_cnt", 32'(nc), 32'd3);
    chk("arb1_video_cnt", 32'(nv), 32'd3);
    idle();

    // Reset while a load is in flight: response dropped, RAM cleared again.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    #1 chk("inflight_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_drop_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy_again", 32'(busy), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wait_clear(n);
    chk("reclear_cycles", 32'(n), 32'd32);
    @(negedge clk);
    core_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    core_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0, 1'b0);
    idle();
    idle();
    idle();
    chk("core_q_drained", 32'(cq.size()), 32'd0);
    chk("video_q_drained", 32'(vq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
Name: dmem_arb

Overview:
- Parametrised successor to the single-cycle data memory: a synchronous single-port word RAM shared by the core load/store port and the video read port.
- Adds load/store size handling (byte/half/word), sign extension, misalignment and range errors, and round-robin arbitration between core and video.
- Adds a post-reset hardware clear sequence in place of initial-block zeroing.
- Sits between the core datapath and data memory; the video scanout reads through the second port.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, at least 4.
- AW, $clog2(DEPTH), word-index width (derived).
- VADDR_W, 9, video byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  core request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse for every accepted core request.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size, or out-of-range access.
- vreq  in  1  video read request.
- vreq_ready  out  1  video request accepted.
- vaddr  in  VADDR_W  video byte address; bits [1:0] are ignored.
- vvalid  out  1  video data valid pulse.
- vdata  out  32  video word.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset: all outputs 0, except busy = 1. FSM enters CLEAR, clear pointer = 0, round-robin flag last_core = 0.
- CLEAR state:
  - Writes 0 to RAM[ptr] each cycle and increments ptr.
  - After writing DEPTH-1, moves to RUN on the next edge; busy clears at that edge.
  - The clear takes exactly DEPTH cycles.
  - req_ready and vreq_ready stay 0 throughout CLEAR.
- RUN state, arbitration (combinational grant):
  - Only core requests: core granted.
  - Only video requests: video granted.
  - Both request: video is granted if last_core = 1, otherwise core.
  - last_core updates on every grant: 1 after a core grant, 0 after a video grant.
  - req_ready = core granted; vreq_ready = video granted.
- Core access decode:
  - Word index = req_addr[AW+1:2].
  - Out of range when req_addr[31:AW+2] != 0.
  - Misaligned when: half access with addr[0] = 1, or word access with addr[1:0] != 0.
  - Any error means no RAM write.
- Stores:
  - Byte enable and data lane shift are derived from size and addr[1:0]: byte → 1 << a; half → 3 << a; word → 4'hF.
  - The write happens on the accept edge.
- Loads:
  - The RAM is read on the accept edge.
  - Size, offset and unsigned are registered with the request.
  - At N+1 the selected lane is extracted and sign- or zero-extended.
- Latency:
  - Request accepted at edge N → resp_valid = 1 for cycle N+1, with resp_rdata and resp_err valid in that cycle.
  - Throughput is one request per cycle; a store followed by a load to the same word in the next cycle returns the new data.
- Video reads:
  - Word index = vaddr[VADDR_W-1:2] truncated or zero-extended to AW.
  - Accepted at edge N → vvalid = 1 with vdata in cycle N+1.
  - No error reporting on the video port.
- Responses are not back-pressured; the consumer must take them.
- Reset asserted mid-operation:
  - Pending responses are dropped (valid outputs go to 0 immediately).
  - The FSM returns to CLEAR and the whole RAM is cleared again.
- resp_rdata and vdata hold their last value when their valid is low. Only the valid flags are meaningful.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SZ_B, SZ_H, SZ_W.
  - Function lane_be(size, off) returning the 4-bit byte enable.
  - Function load_ext(word, size, off, unsigned) returning 32 bits.
- One sub-module, dmem_sram: a DEPTH x 32 synchronous single-port RAM with byte write enables and a registered read.
- Arbiter, clear FSM and response pipeline live in dmem_arb.

Test Plan:
- Reset release with DEPTH = 32:
  - busy stays high exactly 32 cycles.
  - req_ready and vreq_ready are 0 during the clear.
  - A subsequent load from 0x7C returns 0.
- Store sw 0x8000_00F1 @0x10, then lb @0x10 and lbu @0x10:
  - Results 0xFFFF_FFF1 and 0x0000_00F1.
  - lh @0x12 → 0xFFFF_8000.
  - lhu @0x12 → 0x0000_8000.
- sb 0xAB @0x05 over a word previously holding 0x1122_3344:
  - A following lw @0x04 → 0x1122_AB44.
  - Each response arrives one cycle after accept.
- lw @0x06, sh @0x03, size = 11, and lw @0x80 (DEPTH = 32):
  - resp_err = 1 for each, resp_rdata = 0.
  - The RAM is unchanged when checked by readback.
- req_valid and vreq held high continuously for 6 cycles:
  - Grants alternate strictly (core first after reset, since last_core = 0).
  - Each port sees 3 accepts.
  - vdata returns the correct word at N+1.
- Assert rst_n low for 1 cycle while a load is in flight:
  - resp_valid never pulses.
  - busy rises and the clear sequence restarts.
  - Previously stored data reads back as 0 afterwards.
